// File: rtl/sys_defs.sv
// Shared rename/dispatch definitions: register-file sizing and the packets
// exchanged between dispatch, the ROB and the physical-register free list.
package sys_defs;

    localparam int SUPERSCALAR_WAYS = 2;
    localparam int N_PHYS_REG       = 64;
    localparam int N_ARCH_REG       = 32;
    localparam int N_PHYS_REG_BITS  = $clog2(N_PHYS_REG);
    localparam int FL_DEPTH         = N_PHYS_REG - N_ARCH_REG;
    localparam int FL_COUNT_BITS    = $clog2(FL_DEPTH) + 1;
    localparam logic [N_PHYS_REG_BITS-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic [SUPERSCALAR_WAYS-1:0][N_PHYS_REG_BITS-1:0] t_idx;
        logic [SUPERSCALAR_WAYS-1:0]                      t_valid;
        logic [FL_COUNT_BITS-1:0]                         free_count;
    } FREELIST_DISPATCH_PACKET;

    typedef struct packed {
        logic [SUPERSCALAR_WAYS-1:0] new_pr_en;
    } DISPATCH_FREELIST_PACKET;

    typedef struct packed {
        logic [SUPERSCALAR_WAYS-1:0]                      retire_en;
        logic [SUPERSCALAR_WAYS-1:0][N_PHYS_REG_BITS-1:0] retire_told;
    } ROB_FREELIST_PACKET;

endpackage

// File: rtl/way_popcount.sv
// Counts the set bits of a per-way enable vector (allocations or retirements).
module way_popcount
    import sys_defs::*;
#(
    parameter int WAYS = SUPERSCALAR_WAYS,
    localparam int CNT_W = $clog2(WAYS + 1)
) (
    input  logic [WAYS-1:0]  bits_i,
    output logic [CNT_W-1:0] count_o
);

    always_comb begin
        count_o = '0;
        for (int i = 0; i < WAYS; i++) begin
            count_o = count_o + CNT_W'(bits_i[i]);
        end
    end

endmodule

// File: rtl/pr_freelist.sv
// Physical-register free list: circular tag queue with in-order allocate,
// retire-driven reclaim and flush rollback. Define FREELIST_CHECK_EN for err.
module pr_freelist
    import sys_defs::*;
#(
    parameter int WAYS       = SUPERSCALAR_WAYS,
    parameter int N_PHYS_REG = 64,
    parameter int N_ARCH_REG = 32,
    parameter int DEPTH      = N_PHYS_REG - N_ARCH_REG,
    localparam int PR_BITS   = $clog2(N_PHYS_REG),
    localparam int CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [WAYS-1:0]               alloc_en,
    output logic [WAYS-1:0][PR_BITS-1:0]  t_idx,
    output logic [WAYS-1:0]               t_valid,
    output logic [CNT_W-1:0]              free_count,
    input  logic [WAYS-1:0]               retire_en,
    input  logic [WAYS-1:0][PR_BITS-1:0]  retire_told,
    input  logic                          flush
`ifdef FREELIST_CHECK_EN
    ,
    output logic                          err
`endif
);

    localparam int PW   = $clog2(DEPTH);
    localparam int WC_W = $clog2(WAYS + 1);

    logic [PR_BITS-1:0] mem_q [DEPTH];
    logic [PR_BITS-1:0] mem_d [DEPTH];
    logic [PW-1:0]      head_q, head_d;
    logic [PW-1:0]      tail_q, tail_d;
    logic [PW-1:0]      rhead_q, rhead_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [WC_W-1:0]    n_a_raw;
    logic [WC_W-1:0]    n_a;
    logic [WC_W-1:0]    n_r;
    logic [PW-1:0]      wr_off;
    int                 cnt_calc;

    way_popcount #(.WAYS(WAYS)) u_pop_alloc (
        .bits_i  (alloc_en),
        .count_o (n_a_raw)
    );

    way_popcount #(.WAYS(WAYS)) u_pop_retire (
        .bits_i  (retire_en),
        .count_o (n_r)
    );

    // Dispatch is squashed on a flush, so its allocations never land.
    assign n_a = flush ? '0 : n_a_raw;

    always_comb begin
        mem_d  = mem_q;
        wr_off = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (retire_en[i]) begin
                mem_d[tail_q + wr_off] = retire_told[i];
                wr_off = wr_off + PW'(1);
            end
        end
        tail_d   = tail_q + PW'(n_r);
        rhead_d  = rhead_q + PW'(n_r);
        head_d   = flush ? rhead_d : head_q + PW'(n_a);
        cnt_calc = int'(count_q) - int'(n_a) + int'(n_r);
        if (flush) begin
            count_d = CNT_W'(DEPTH);
`ifdef FREELIST_CHECK_EN
        end else if (cnt_calc < 0) begin
            count_d = '0;
        end else if (cnt_calc > DEPTH) begin
            count_d = CNT_W'(DEPTH);
`endif
        end else begin
            count_d = CNT_W'(cnt_calc);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= PR_BITS'(N_ARCH_REG + i);
            end
            head_q  <= '0;
            tail_q  <= '0;
            rhead_q <= '0;
            count_q <= CNT_W'(DEPTH);
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            rhead_q <= rhead_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        for (int k = 0; k < WAYS; k++) begin
            t_idx[k]   = mem_q[head_q + PW'(k)];
            t_valid[k] = (k < int'(count_q));
        end
    end

    assign free_count = count_q;

`ifdef FREELIST_CHECK_EN
    logic err_q, err_d;
    logic zero_free;

    always_comb begin
        zero_free = 1'b0;
        for (int i = 0; i < WAYS; i++) begin
            if (retire_en[i] && retire_told[i] == '0) begin
                zero_free = 1'b1;
            end
        end
        err_d = err_q
              | (!flush && (int'(n_a) > int'(count_q)))
              | (cnt_calc > DEPTH)
              | zero_free;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_pr_freelist.sv
// Directed bench for pr_freelist with default sizing (2 ways, 64/32 regs).
module tb_pr_freelist;

    logic            clock;
    logic            reset_n;
    logic [1:0]      alloc_en;
    logic [1:0][5:0] t_idx;
    logic [1:0]      t_valid;
    logic [5:0]      free_count;
    logic [1:0]      retire_en;
    logic [1:0][5:0] retire_told;
    logic            flush;
`ifdef FREELIST_CHECK_EN
    logic            err;
`endif

    int checks = 0;
    int errors = 0;

    pr_freelist dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .alloc_en    (alloc_en),
        .t_idx       (t_idx),
        .t_valid     (t_valid),
        .free_count  (free_count),
        .retire_en   (retire_en),
        .retire_told (retire_told),
        .flush       (flush)
`ifdef FREELIST_CHECK_EN
        ,
        .err         (err)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Inputs are applied 1 time unit after a rising edge and held for one cycle;
    // outputs are read at the same offset, well away from the edge.
    task automatic step(input logic [1:0] a, input logic [1:0] r,
                        input logic [5:0] told0, input logic [5:0] told1,
                        input logic fl);
        alloc_en       = a;
        retire_en      = r;
        retire_told[0] = told0;
        retire_told[1] = told1;
        flush          = fl;
        @(posedge clock);
        #1;
        alloc_en  = 2'b00;
        retire_en = 2'b00;
        flush     = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        step(2'b11, 2'b00, 6'd0, 6'd0, 1'b0);
        step(2'b01, 2'b00, 6'd0, 6'd0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (t_idx[0] !== 6'd32 || t_idx[1] !== 6'd33) begin
            errors++;
            $display("FAIL reset_t_idx: got {%0d,%0d} expected {32,33}", t_idx[0], t_idx[1]);
        end
        checks++;
        if (t_valid !== 2'b11) begin
            errors++;
            $display("FAIL reset_t_valid: got %b expected 11", t_valid);
        end
        checks++;
        if (free_count !== 6'd32) begin
            errors++;
            $display("FAIL reset_free_count: got %0d expected 32", free_count);
        end
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic test_alloc();
        do_reset();
        step(2'b11, 2'b00, 6'd0, 6'd0, 1'b0);
        checks++;
        if (t_idx[0] !== 6'd34 || t_idx[1] !== 6'd35) begin
            errors++;
            $display("FAIL alloc11_t_idx: got {%0d,%0d} expected {34,35}", t_idx[0], t_idx[1]);
        end
        checks++;
        if (free_count !== 6'd30) begin
            errors++;
            $display("FAIL alloc11_free_count: got %0d expected 30", free_count);
        end
        step(2'b10, 2'b00, 6'd0, 6'd0, 1'b0);
        checks++;
        if (t_idx[0] !== 6'd35 || t_idx[1] !== 6'd36) begin
            errors++;
            $display("FAIL alloc10_t_idx: got {%0d,%0d} expected {35,36}", t_idx[0], t_idx[1]);
        end
        checks++;
        if (free_count !== 6'd29) begin
            errors++;
            $display("FAIL alloc10_free_count: got %0d expected 29", free_count);
        end
    endtask

    task automatic test_drain_refill();
        do_reset();
        for (int i = 0; i < 16; i++) step(2'b11, 2'b00, 6'd0, 6'd0, 1'b0);
        checks++;
        if (free_count !== 6'd0) begin
            errors++;
            $display("FAIL drain_free_count: got %0d expected 0", free_count);
        end
        checks++;
        if (t_valid !== 2'b00) begin
            errors++;
            $display("FAIL drain_t_valid: got %b expected 00", t_valid);
        end
        step(2'b00, 2'b11, 6'd5, 6'd7, 1'b0);
        checks++;
        if (t_idx[0] !== 6'd5 || t_idx[1] !== 6'd7) begin
            errors++;
            $display("FAIL refill_t_idx: got {%0d,%0d} expected {5,7}", t_idx[0], t_idx[1]);
        end
        checks++;
        if (free_count !== 6'd2) begin
            errors++;
            $display("FAIL refill_free_count: got %0d expected 2", free_count);
        end
        checks++;
        if (t_valid !== 2'b11) begin
            errors++;
            $display("FAIL refill_t_valid: got %b expected 11", t_valid);
        end
    endtask

    // Leaves the list with free_count = 1, head = 0, tail = 1.
    task automatic test_flush();
        do_reset();
        step(2'b11, 2'b00, 6'd0, 6'd0, 1'b0);
        step(2'b01, 2'b00, 6'd0, 6'd0, 1'b0);
        step(2'b11, 2'b01, 6'd10, 6'd0, 1'b1);
        checks++;
        if (free_count !== 6'd32) begin
            errors++;
            $display("FAIL flush_free_count: got %0d expected 32", free_count);
        end
        checks++;
        if (t_idx[0] !== 6'd33) begin
            errors++;
            $display("FAIL flush_t_idx0: got %0d expected 33", t_idx[0]);
        end
        for (int i = 0; i < 15; i++) step(2'b11, 2'b00, 6'd0, 6'd0, 1'b0);
        step(2'b01, 2'b00, 6'd0, 6'd0, 1'b0);
        checks++;
        if (t_idx[0] !== 6'd10) begin
            errors++;
            $display("FAIL flush_pos31_tag: got %0d expected 10", t_idx[0]);
        end
        checks++;
        if (free_count !== 6'd1 || t_valid !== 2'b01) begin
            errors++;
            $display("FAIL flush_pos31_count: got %0d/%b expected 1/01", free_count, t_valid);
        end
    endtask

    task automatic test_simultaneous();
        alloc_en       = 2'b01;
        retire_en      = 2'b11;
        retire_told[0] = 6'd40;
        retire_told[1] = 6'd41;
        #1;
        checks++;
        if (t_valid !== 2'b01 || free_count !== 6'd1 || t_idx[0] !== 6'd10) begin
            errors++;
            $display("FAIL simul_no_forward: got %b/%0d/%0d expected 01/1/10",
                     t_valid, free_count, t_idx[0]);
        end
        @(posedge clock);
        #1;
        alloc_en  = 2'b00;
        retire_en = 2'b00;
        checks++;
        if (free_count !== 6'd2) begin
            errors++;
            $display("FAIL simul_free_count: got %0d expected 2", free_count);
        end
        checks++;
        if (t_idx[0] !== 6'd40 || t_idx[1] !== 6'd41) begin
            errors++;
            $display("FAIL simul_t_idx: got {%0d,%0d} expected {40,41}", t_idx[0], t_idx[1]);
        end
    endtask

`ifdef FREELIST_CHECK_EN
    task automatic test_check();
        do_reset();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL check_err_reset: got %b expected 0", err);
        end
        for (int i = 0; i < 15; i++) step(2'b11, 2'b00, 6'd0, 6'd0, 1'b0);
        step(2'b01, 2'b00, 6'd0, 6'd0, 1'b0);
        step(2'b11, 2'b00, 6'd0, 6'd0, 1'b0);
        checks++;
        if (err !== 1'b1 || free_count !== 6'd0) begin
            errors++;
            $display("FAIL check_overalloc: got err=%b count=%0d expected err=1 count=0", err, free_count);
        end
        step(2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
        step(2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL check_sticky: got %b expected 1", err);
        end
        do_reset();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL check_cleared: got %b expected 0", err);
        end
    endtask
`endif

    initial begin
        reset_n     = 1'b0;
        alloc_en    = 2'b00;
        retire_en   = 2'b00;
        retire_told = '0;
        flush       = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        test_reset();
        test_alloc();
        test_drain_refill();
        test_flush();
        test_simultaneous();
`ifdef FREELIST_CHECK_EN
        test_check();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pr_freelist.md
# pr_freelist

Physical-register free list and allocator for the rename/dispatch stage. It holds every physical register tag that is not architecturally or speculatively mapped, presents the next `WAYS` free tags to dispatch each cycle, and consumes them in program order. It reclaims old tags (`told`) from ROB retirement. On a branch flush it rolls speculative allocations back to the retirement point.

## Interface
Parameters:
- `WAYS`, default `SUPERSCALAR_WAYS` (2): dispatch/retire width.
- `N_PHYS_REG`, default 64: number of physical registers.
- `N_ARCH_REG`, default 32: number of architectural registers.
- `DEPTH`, default `N_PHYS_REG-N_ARCH_REG` (32): list capacity; must be a power of two.

Ports (clock is single; reset is asynchronous, active-low):
- `clock` in 1: sole clock; all state updates on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `alloc_en` in `WAYS`: dispatch consumes one tag per set bit (`new_pr_en`). Bits need not be contiguous; the k-th set bit takes `t_idx[k]`.
- `t_idx` out `WAYS`×`N_PHYS_REG_BITS`: next free tags in list order; `t_idx[k]` = entry at `head+k`.
- `t_valid` out `WAYS`: `t_valid[k]` = (k < `free_count`).
- `free_count` out `$clog2(DEPTH)+1`: number of free tags held.
- `retire_en` in `WAYS`: retiring instruction `i` had a non-zero destination.
- `retire_told` in `WAYS`×`N_PHYS_REG_BITS`: tag freed by retiring instruction `i`.
- `flush` in 1: branch misprediction recovery at retire.
- `err` out 1: present only with `FREELIST_CHECK_EN`.

## Operation
- Storage: circular array `DEPTH` entries, `head`, `tail`, and `retire_head` pointers (`$clog2(DEPTH)` bits, wrap modulo `DEPTH`), plus `count` register.
- Reset (async): entry `i` = `N_ARCH_REG+i`; `head` = `tail` = `retire_head` = 0; `count` = `DEPTH`. Reset output values: `t_idx[k]` = `N_ARCH_REG+k`, `t_valid` all ones, `free_count` = `DEPTH`, `err` = 0.
- Allocate: `n_a` = popcount(`alloc_en`). The `head` pointer advances by `n_a`. Dispatch guarantees `n_a` ≤ `free_count`.
- Free: the set `retire_en` bits, in ascending way order, write `retire_told` to `tail`, `tail+1`, …. The `tail` pointer advances by `n_r` = popcount(`retire_en`). `retire_head` also advances by `n_r`, because every retiring instruction with a destination consumed exactly one allocation, in order.
- Count: `count_next` = `count` − `n_a` + `n_r`.
- Flush: retirement in the same cycle is applied first (tail and `retire_head` advance). Then `head` := new `retire_head` and `count` := `DEPTH`. All `alloc_en` in a flush cycle are ignored.
- Simultaneous allocate and free in one cycle are legal. Freed tags are not forwarded to allocation: a tag written at `tail` appears on `t_idx` no earlier than the next cycle.
- Zero tags: retire logic never asserts `retire_en` with `retire_told` = 0. Dispatch never allocates for `ZERO_REG` destinations.

## Timing
- `t_idx`, `t_valid`, and `free_count` are combinational from registered state only; they have no dependence on same-cycle inputs.
- Allocation takes effect at the edge where `alloc_en` is sampled. New tags are visible immediately after that edge.
- Free-to-reuse latency is 1 cycle minimum.
- Flush takes effect at the sampling edge. In the next cycle, outputs reflect the restored `head` and `free_count` = `DEPTH`.
- Deassertion of `reset_n` must be synchronous to `clock` (the integration level handles this); assertion acts immediately.

## Configuration
- Macro `FREELIST_CHECK_EN` defined:
  - Adds output `err`, a sticky bit cleared only by reset.
  - `err` is set on over-allocation: `n_a` > `count` in a non-flush cycle.
  - `err` is set on over-free: `count` − `n_a` + `n_r` > `DEPTH`.
  - `err` is set on freeing tag 0.
  - The offending cycle's state update still occurs, with `count` saturated at 0 or `DEPTH`.
- Macro undefined: the `err` port and all checking logic are absent; behaviour under protocol violation is undefined.

## Structure
- Shared package `sys_defs`:
  - `N_PHYS_REG`, `N_ARCH_REG`, `N_PHYS_REG_BITS`, `SUPERSCALAR_WAYS`, `ZERO_REG`.
  - `FREELIST_DISPATCH_PACKET` carries `t_idx`, `t_valid`, and `free_count`.
  - `DISPATCH_FREELIST_PACKET` carries `new_pr_en`.
  - A new `ROB_FREELIST_PACKET` carries `retire_en` and `retire_told`.
- One sub-module, `way_popcount`, parameterized on `WAYS`, used for both `n_a` and `n_r`.

## Test plan
Defaults apply: `WAYS` = 2, `N_PHYS_REG` = 64, `N_ARCH_REG` = 32, `DEPTH` = 32.
- Reset: assert `reset_n` low mid-run → immediately `t_idx` = {32,33}, `t_valid` = 2'b11, `free_count` = 32.
- Allocate: `alloc_en` = 2'b11 for one cycle → `t_idx` = {34,35}, `free_count` = 30. Then `alloc_en` = 2'b10 → `t_idx` = {35,36}, `free_count` = 29.
- Drain and refill: allocate all 32 tags → `free_count` = 0, `t_valid` = 00. Then `retire_en` = 11 with `retire_told` = {5,7} → next cycle `t_idx` = {5,7}, `free_count` = 2 (tail wrapped to 0).
- Flush with retire: after allocating 32, 33, 34, apply `retire_en` = 01 with `retire_told[0]` = 10 together with `flush` → next cycle `free_count` = 32, `t_idx[0]` = 33. Entry 10 is present at position 31.
- Simultaneous allocate and free: at `free_count` = 1, apply `alloc_en` = 01 and `retire_en` = 11 → `free_count` = 2. Freed tags appear in the following cycle, not the current one.
- Check (`FREELIST_CHECK_EN` defined): at `free_count` = 1, apply `alloc_en` = 11 → `err` = 1, `free_count` = 0. `err` stays at 1 until reset.
